// File: rtl/mem_stage_dmem_ctrl.sv
// Memory-stage data-port controller: issues one cache access per EX/MEM instruction,
// stalls until the response (or watchdog expiry), and formats load results.
module mem_stage_dmem_ctrl #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        trap,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_aligned,
  input  logic [1:0]  bit_shift,
  input  logic [3:0]  rmask,
  input  logic [3:0]  wmask,
  input  logic [31:0] write_data,
  input  logic        advance,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [31:0] LP_WD_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_dmem_address;
  logic        r_dmem_read;
  logic        r_dmem_write;
  logic [3:0]  r_dmem_wmask;
  logic [31:0] r_dmem_wdata;
  logic [31:0] r_load_data;
  logic        r_done;
  logic        r_timeout_err;
  logic [2:0]  r_funct3;
  logic [1:0]  r_shift;
  logic [31:0] r_wd_cnt;

  logic        w_req;
  logic        w_timeout;
  logic [31:0] w_shifted;
  logic [31:0] w_load_fmt;
  logic        w_unused;

  assign w_req     = (is_load | is_store) & ~trap;
  // Response wins over an expiring watchdog in the same cycle.
  assign w_timeout = (TIMEOUT != 0) && !dmem_resp && (r_wd_cnt == LP_WD_LAST);
  assign w_unused  = ^rmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_next    = r_state;
    mem_stall = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          mem_stall = 1'b1;
          w_next    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_stall = 1'b1;
        if (dmem_resp || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        if (advance) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shifted = dmem_rdata >> {r_shift, 3'b000};
    unique case (r_funct3)
      3'b000:  w_load_fmt = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_fmt = {24'd0, w_shifted[7:0]};
      3'b001:  w_load_fmt = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_fmt = {16'd0, w_shifted[15:0]};
      default: w_load_fmt = w_shifted;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dmem_address <= '0;
      r_dmem_read    <= 1'b0;
      r_dmem_write   <= 1'b0;
      r_dmem_wmask   <= '0;
      r_dmem_wdata   <= '0;
      r_load_data    <= '0;
      r_done         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_funct3       <= '0;
      r_shift        <= '0;
      r_wd_cnt       <= '0;
    end else begin
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_dmem_address <= addr_aligned;
            r_dmem_read    <= is_load;
            r_dmem_write   <= is_store;
            r_dmem_wmask   <= is_store ? wmask : 4'b0000;
            r_dmem_wdata   <= write_data << {bit_shift, 3'b000};
            r_funct3       <= funct3;
            r_shift        <= bit_shift;
            r_wd_cnt       <= '0;
          end
        end
        S_ACCESS: begin
          if (dmem_resp) begin
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            r_done       <= 1'b1;
            if (r_dmem_read) r_load_data <= w_load_fmt;
          end else if (w_timeout) begin
            r_dmem_read   <= 1'b0;
            r_dmem_write  <= 1'b0;
            r_done        <= 1'b1;
            r_timeout_err <= 1'b1;
            if (r_dmem_read) r_load_data <= '0;
          end else begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_address = r_dmem_address;
  assign dmem_read    = r_dmem_read;
  assign dmem_write   = r_dmem_write;
  assign dmem_wmask   = r_dmem_wmask;
  assign dmem_wdata   = r_dmem_wdata;
  assign load_data    = r_load_data;
  assign done         = r_done;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed bench for mem_stage_dmem_ctrl: loads, stores, hold in DONE, watchdog, trap and async reset.
module tb_mem_stage_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_load, is_store, trap, advance, dmem_resp;
  logic [2:0]  funct3;
  logic [31:0] addr_aligned, write_data, dmem_rdata;
  logic [1:0]  bit_shift;
  logic [3:0]  rmask, wmask;
  logic [31:0] dmem_address, dmem_wdata, load_data;
  logic        dmem_read, dmem_write, mem_stall, done, timeout_err;
  logic [3:0]  dmem_wmask;

  int checks = 0;
  int errors = 0;
  int n;

  mem_stage_dmem_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .is_load(is_load), .is_store(is_store), .trap(trap),
    .funct3(funct3), .addr_aligned(addr_aligned), .bit_shift(bit_shift),
    .rmask(rmask), .wmask(wmask), .write_data(write_data), .advance(advance),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_stall(mem_stall), .load_data(load_data), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; is_load = 0; is_store = 0; trap = 0; advance = 0; dmem_resp = 0;
    funct3 = 3'b000; addr_aligned = 0; write_data = 0; dmem_rdata = 0;
    bit_shift = 0; rmask = 0; wmask = 0;
    #12;
    check("rst_read", {31'd0, dmem_read}, 32'd0);
    check("rst_addr", dmem_address, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    rst = 1'b0;
    tick();

    // lb, shift 3, response in the first ACCESS cycle
    is_load = 1; funct3 = 3'b000; addr_aligned = 32'h0000_1000; bit_shift = 2'd3; rmask = 4'b1000;
    #1;
    check("lb_stall_idle", {31'd0, mem_stall}, 32'd1);
    tick();
    check("lb_read", {31'd0, dmem_read}, 32'd1);
    check("lb_addr", dmem_address, 32'h0000_1000);
    check("lb_stall_access", {31'd0, mem_stall}, 32'd1);
    dmem_resp = 1; dmem_rdata = 32'h80FF_1234;
    tick();
    dmem_resp = 0; dmem_rdata = 0;
    #1;
    check("lb_read_drop", {31'd0, dmem_read}, 32'd0);
    check("lb_done", {31'd0, done}, 32'd1);
    check("lb_load_data", load_data, 32'hFFFF_FF80);
    check("lb_stall_done", {31'd0, mem_stall}, 32'd0);

    // hold in DONE with req still asserted: no re-issue, no stall
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_read", {31'd0, dmem_read}, 32'd0);
      check("hold_stall", {31'd0, mem_stall}, 32'd0);
      check("hold_done", {31'd0, done}, 32'd0);
    end
    advance = 1;
    tick();
    advance = 0; is_load = 0;
    #1;
    check("opreg_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("opreg_read", {31'd0, dmem_read}, 32'd0);
    check("opreg_done", {31'd0, done}, 32'd0);

    // lhu, shift 2, response after 5 extra ACCESS cycles
    is_load = 1; funct3 = 3'b101; addr_aligned = 32'h0000_1100; bit_shift = 2'd2; rmask = 4'b1100;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      dmem_resp  = (i == 6);
      dmem_rdata = (i == 6) ? 32'hBEEF_0000 : 32'h0;
      #1;
      if (mem_stall) n++;
      tick();
    end
    dmem_resp = 0; dmem_rdata = 0;
    #1;
    if (mem_stall) n++;
    check("lhu_stall_cycles", n, 32'd7);
    check("lhu_load_data", load_data, 32'h0000_BEEF);
    check("lhu_done", {31'd0, done}, 32'd1);
    advance = 1;
    tick();
    advance = 0; is_load = 0;

    // sh, shift 2
    is_store = 1; funct3 = 3'b001; addr_aligned = 32'h0000_2000; bit_shift = 2'd2;
    write_data = 32'h1234_ABCD; wmask = 4'b1100;
    tick();
    check("sh_write", {31'd0, dmem_write}, 32'd1);
    check("sh_read", {31'd0, dmem_read}, 32'd0);
    check("sh_wdata", dmem_wdata, 32'hABCD_0000);
    check("sh_wmask", {28'd0, dmem_wmask}, 32'h0000_000C);
    dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_resp = 0; dmem_rdata = 0;
    check("sh_write_drop", {31'd0, dmem_write}, 32'd0);
    check("sh_done", {31'd0, done}, 32'd1);
    check("sh_load_data_kept", load_data, 32'h0000_BEEF);
    advance = 1;
    tick();
    advance = 0; is_store = 0; wmask = 0;

    // lw with no response: watchdog expires after 8 ACCESS cycles
    is_load = 1; funct3 = 3'b010; addr_aligned = 32'h0000_3000; bit_shift = 2'd0; rmask = 4'b1111;
    tick();
    n = 0;
    for (int i = 0; i < 20 && dmem_read; i++) begin
      n++;
      tick();
    end
    check("wd_held_cycles", n, 32'd8);
    check("wd_timeout_err", {31'd0, timeout_err}, 32'd1);
    check("wd_done", {31'd0, done}, 32'd1);
    check("wd_load_data", load_data, 32'd0);
    dmem_resp = 1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_resp = 0; dmem_rdata = 0;
    check("wd_late_load_data", load_data, 32'd0);
    check("wd_late_done", {31'd0, done}, 32'd0);
    check("wd_err_pulse", {31'd0, timeout_err}, 32'd0);
    advance = 1;
    tick();
    advance = 0; is_load = 0;

    // trapped load: no access, no stall
    is_load = 1; trap = 1;
    #1;
    check("trap_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("trap_read", {31'd0, dmem_read}, 32'd0);

    // async reset mid-ACCESS
    trap = 0;
    tick();
    check("rstacc_read_pre", {31'd0, dmem_read}, 32'd1);
    rst = 1;
    #1;
    check("rstacc_read_async", {31'd0, dmem_read}, 32'd0);
    is_load = 0;
    #1;
    check("rstacc_idle_stall", {31'd0, mem_stall}, 32'd0);
    rst = 0;
    dmem_resp = 1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_resp = 0; dmem_rdata = 0;
    check("rstacc_late_done", {31'd0, done}, 32'd0);
    check("rstacc_late_load", load_data, 32'd0);
    check("rstacc_late_stall", {31'd0, mem_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_dmem_ctrl.md
Name: mem_stage_dmem_ctrl

Overview:
Memory-stage data-port controller on the consumer side of the EX/MEM stage register. It takes the registered memory request (aligned address, byte shift, read/write masks, store data, funct3), drives the data-cache request/response handshake, and stalls the pipeline until the access completes. On loads it shifts and sign- or zero-extends the returned word into a registered writeback value. Non-memory and trapped instructions pass through with no access and no stall.

Parameters:
TIMEOUT, 0, response watchdog in cycles; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
is_load  in  1  EX/MEM holds a load (opcode op_load)
is_store  in  1  EX/MEM holds a store (opcode op_store)
trap  in  1  EX/MEM trap flag; suppresses the access
funct3  in  3  load/store funct3
addr_aligned  in  32  word-aligned address, bits [1:0] = 00
bit_shift  in  2  byte offset within the word
rmask  in  4  read byte mask
wmask  in  4  write byte mask
write_data  in  32  unshifted store data (rs2 value)
advance  in  1  EX/MEM register loads a new instruction at this edge
dmem_address  out  32  cache request address
dmem_read  out  1  cache read request
dmem_write  out  1  cache write request
dmem_wmask  out  4  cache byte enables
dmem_wdata  out  32  shifted store data
dmem_rdata  in  32  cache read data, valid when dmem_resp = 1
dmem_resp  in  1  cache response, single-cycle pulse
mem_stall  out  1  hold all upstream stage registers
load_data  out  32  formatted load result, registered
done  out  1  one-cycle pulse when an access completes
timeout_err  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- The block defines req = (is_load | is_store) & ~trap.
- FSM states: IDLE, ACCESS, DONE. Reset (asynchronous, effective immediately) puts the FSM in IDLE and clears every registered output: dmem_* = 0, load_data = 0, done = 0, timeout_err = 0. The watchdog counter also resets to 0.
- IDLE, req = 1: mem_stall = 1 (combinational). Next state is ACCESS. At this edge the block registers the following:
  - dmem_address = addr_aligned.
  - dmem_read = is_load; dmem_write = is_store.
  - dmem_wmask = wmask for stores, 0 for loads.
  - dmem_wdata = write_data << (8*bit_shift).
  - funct3 and bit_shift are latched for the response.
- IDLE, req = 0: mem_stall = 0, no request is issued, and the FSM stays in IDLE.
- ACCESS: dmem_* outputs stay stable until the response; mem_stall = 1.
  - On dmem_resp = 1, the FSM clears dmem_read/dmem_write at the edge and pulses done. For loads it also writes load_data. Next state is DONE.
  - Minimum latency, request to done: 2 cycles, with mem_stall high for exactly 2 cycles.
- Load formatting: s = dmem_rdata >> (8*latched bit_shift).
  - lb (000): sign-extend s[7:0].
  - lbu (100): zero-extend s[7:0].
  - lh (001): sign-extend s[15:0].
  - lhu (101): zero-extend s[15:0].
  - lw (010) and any other encoding: s.
- Stores leave load_data unchanged.
- DONE: mem_stall = 0 and no new request is issued, even if req is still 1. This prevents re-issuing the same instruction. If advance = 1, next state is IDLE; otherwise the FSM stays in DONE.
- advance is ignored in IDLE and ACCESS. The stall keeps upstream from advancing.
- Watchdog (TIMEOUT > 0): the counter increments each ACCESS cycle without dmem_resp. When the count reaches TIMEOUT:
  - dmem_read/dmem_write drop, timeout_err pulses, and done pulses.
  - load_data = 0 for loads.
  - Next state is DONE.
  - A dmem_resp arriving in that same cycle takes priority: normal completion, no error.
  - The counter clears on entry to ACCESS.
- A dmem_resp while in IDLE or DONE is ignored.
- Reset during ACCESS drops the request immediately. Any later dmem_resp is ignored.

Test Plan:
- lb, bit_shift = 3, addr_aligned = 0x00001000, dmem_rdata = 0x80FF1234 with resp in the first ACCESS cycle -> dmem_address = 0x00001000, dmem_read = 1 for 1 cycle, load_data = 0xFFFFFF80, done pulses, mem_stall high for 2 cycles.
- lhu, bit_shift = 2, dmem_rdata = 0xBEEF0000, resp delayed 5 cycles -> mem_stall high for 7 cycles, load_data = 0x0000BEEF.
- sh, bit_shift = 2, write_data = 0x1234ABCD, wmask = 1100 -> dmem_write = 1, dmem_wdata = 0xABCD0000, dmem_wmask = 1100; after resp, load_data is unchanged.
- Load completes, then advance is held 0 for 4 cycles with req still 1 -> no second request and mem_stall = 0. Then advance = 1 followed by an op_reg instruction -> no access and no stall.
- TIMEOUT = 8, load with no resp -> the request is held for 8 cycles, then timeout_err and done pulse together and load_data = 0. A subsequent late resp is ignored.
- trap = 1 with is_load = 1 -> no dmem_read and mem_stall = 0. Separately, assert rst asynchronously mid-ACCESS -> dmem_read falls without a clock edge, and the FSM is in IDLE.
